// File: rtl/servant_tx_arbiter.sv
// rtl/servant_tx_arbiter.sv - shares the UART TX pin between the servant core and a HW byte serializer
//
// The servant core's bit-banged serial output always wins. The hardware byte
// serializer may only start a frame once the core line has been continuously
// high for IDLE_BITS bit-times, and then owns the pin for one 8N1 frame.
//
// Ports:
//   wb_clk      in   system clock, all logic on the rising edge
//   wb_rst      in   synchronous active-high reset
//   i_core_tx   in   servant bit-banged serial output (same clock domain)
//   i_hw_data   in   [7:0] byte offered by the HW requester
//   i_hw_valid  in   i_hw_data is valid
//   o_hw_ready  out  arbiter accepts a HW byte this cycle (registered)
//   o_tx        out  shared UART TX pin, idle high
//   o_hw_grant  out  high while a HW frame owns o_tx
//   o_collision out  one-cycle pulse: core started a frame while HW owned the line
module servant_tx_arbiter #(
    parameter int CLKS_PER_BIT = 278,
    parameter int IDLE_BITS    = 12
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       i_core_tx,
    input  logic [7:0] i_hw_data,
    input  logic       i_hw_valid,
    output logic       o_hw_ready,
    output logic       o_tx,
    output logic       o_hw_grant,
    output logic       o_collision
);

    localparam int QMAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int QW   = $clog2(QMAX + 1);
    localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CORE = 2'd1,
        S_HW   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [QW-1:0]   qcnt;
    logic [9:0]      shift;
    logic [BW-1:0]   baud;
    logic [3:0]      bitcnt;
    logic            core_d;
    logic            ready;
    logic            coll;

    logic            quiet;
    logic            transfer;
    logic            bit_end;
    logic            frame_end;

    assign quiet     = (qcnt == QW'(QMAX));
    assign transfer  = i_hw_valid & ready;
    assign bit_end   = (baud == BW'(CLKS_PER_BIT - 1));
    assign frame_end = bit_end && (bitcnt == 4'd9);

    assign o_hw_ready  = ready;
    assign o_hw_grant  = (state == S_HW);
    assign o_collision = coll;

    // Ready can only be high in IDLE, so an accepted byte always starts from
    // IDLE; the accepted transfer wins even if the core line drops that cycle.
    always_comb begin
        state_next = state;
        o_tx       = i_core_tx;
        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_next = S_HW;
                end else if (!i_core_tx) begin
                    state_next = S_CORE;
                end
            end
            S_CORE: begin
                if (quiet) begin
                    state_next = S_IDLE;
                end
            end
            S_HW: begin
                o_tx = shift[0];
                if (frame_end) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state  <= S_IDLE;
            qcnt   <= '0;
            shift  <= '1;
            baud   <= '0;
            bitcnt <= '0;
            core_d <= 1'b1;
            ready  <= 1'b0;
            coll   <= 1'b0;
        end else begin
            state  <= state_next;
            core_d <= i_core_tx;

            // Quiet counter runs in every state, including during a HW frame.
            if (!i_core_tx) begin
                qcnt <= '0;
            end else if (!quiet) begin
                qcnt <= qcnt + QW'(1);
            end

            // Ready is re-armed on the same edge a frame ends, which leaves a
            // single pass-through cycle between back-to-back HW frames.
            ready <= (state_next == S_IDLE) && quiet;

            // A core falling edge under a HW frame, or a low core line in the
            // handshake cycle itself, means the core's bits are being dropped.
            coll <= ((state == S_HW) && core_d && !i_core_tx) ||
                    (transfer && !i_core_tx);

            if ((state == S_IDLE) && transfer) begin
                shift  <= {1'b1, i_hw_data, 1'b0};
                baud   <= '0;
                bitcnt <= '0;
            end else if (state == S_HW) begin
                if (bit_end) begin
                    baud   <= '0;
                    shift  <= {1'b1, shift[9:1]};
                    bitcnt <= bitcnt + 4'd1;
                end else begin
                    baud <= baud + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_servant_tx_arbiter.sv
// tb/tb_servant_tx_arbiter.sv - randomized self-checking bench for servant_tx_arbiter
module tb_servant_tx_arbiter;

    localparam int CPB   = 4;
    localparam int IB    = 2;
    localparam int QMAX  = CPB * IB;
    localparam int FRAME = 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       core  = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       hw_ready;
    logic       tx;
    logic       hw_grant;
    logic       collision;

    always #5 clk = ~clk;

    servant_tx_arbiter #(
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (IB)
    ) dut (
        .wb_clk     (clk),
        .wb_rst     (rst),
        .i_core_tx  (core),
        .i_hw_data  (data),
        .i_hw_valid (valid),
        .o_hw_ready (hw_ready),
        .o_tx       (tx),
        .o_hw_grant (hw_grant),
        .o_collision(collision)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the line is described by how long the core has been
    // high, whether a frame is on the wire and how old it is, and whether the
    // core currently owns the line.
    int         run       = 0;
    bit         in_frame  = 0;
    int         age       = 0;
    logic [7:0] fbyte     = 8'h00;
    bit         core_busy = 0;
    bit         m_ready   = 0;
    bit         m_coll    = 0;
    bit         prev_core = 1;
    bit         xfer;
    bit         nf;
    bit         nb;
    int         nage;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            run = 0; in_frame = 0; age = 0; core_busy = 0;
            m_ready = 0; m_coll = 0; prev_core = 1;
        end else begin
            xfer   = valid && m_ready;
            m_coll = (in_frame && prev_core && !core) || (xfer && !core);
            nf = in_frame; nb = core_busy; nage = age + 1;
            if (in_frame) begin
                if (age == FRAME - 1) nf = 0;
            end else if (xfer) begin
                nf = 1; nage = 0; fbyte = data; nb = 0;
            end else if (!core_busy && !core) begin
                nb = 1;
            end else if (core_busy && run == QMAX) begin
                nb = 0;
            end
            m_ready   = !nf && !nb && (run == QMAX);
            run       = core ? ((run < QMAX) ? run + 1 : QMAX) : 0;
            prev_core = core;
            in_frame  = nf;
            core_busy = nb;
            age       = nage;
        end
    end

    task automatic step(input logic r, input logic c, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r; core = c; valid = v; data = d;
        #1;
        check("o_tx", tx, in_frame ? frame_bit(fbyte, age / CPB) : core);
        check("o_hw_ready", hw_ready, m_ready);
        check("o_hw_grant", hw_grant, in_frame);
        check("o_collision", collision, m_coll);
    endtask

    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   k;
    int   cnt;
    int   cnt2;
    logic cur;

    initial begin
        repeat (3) step(1, 1, 0, 8'h00);

        // Latency from reset release to the first ready, then an A5 frame.
        k = 0;
        do begin
            step(0, 1, 1, 8'hA5);
            k++;
        end while (!hw_ready && k < 30);
        check("ready_latency", k - 1, 9);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(0, 1, 0, 8'h00);
            if (hw_grant) cnt++;
            if (i % CPB == CPB / 2) check($sformatf("a5_bit%0d", i / CPB), tx, exp_bits[i / CPB]);
        end
        check("a5_grant_cycles", cnt, FRAME);
        repeat (3) step(0, 1, 0, 8'h00);

        // Core traffic while idle passes straight through and resets the quiet wait.
        repeat (4) step(0, 0, 0, 8'h00);
        k = 0;
        do begin
            step(0, 1, 0, 8'h00);
            k++;
        end while (!hw_ready && k < 30);
        check("quiet_wait", k, 10);

        // Back-to-back frames: 00 then 01.
        k = 0;
        do begin
            step(0, 1, 1, 8'h00);
            k++;
        end while (!hw_grant && k < 30);
        check("b2b_first_grant", hw_grant, 1);
        k = 0;
        do begin
            step(0, 1, 1, 8'h01);
            k++;
        end while (hw_grant && k < 60);
        cnt = 0;
        while (!hw_grant && cnt < 10) begin
            cnt++;
            step(0, 1, 1, 8'h01);
        end
        check("b2b_gap", cnt, 1);
        for (int i = 1; i < FRAME; i++) begin
            step(0, 1, 0, 8'h00);
            if (i == CPB + 1) check("second_frame_d0", tx, 1);
        end
        repeat (10) step(0, 1, 0, 8'h00);

        // Core falls at bit 3 of a HW frame and stays low past the frame end.
        k = 0;
        do begin
            step(0, 1, 1, 8'h3C);
            k++;
        end while (!hw_grant && k < 30);
        cnt = 0;
        for (int i = 1; i < FRAME + 6; i++) begin
            step(0, (i >= 3 * CPB) ? 1'b0 : 1'b1, 0, 8'h00);
            if (collision) cnt++;
        end
        check("collision_pulses", cnt, 1);
        check("core_after_frame", tx, 0);

        // Core drops in the very cycle the handshake is taken.
        k = 0;
        do begin
            step(0, 1, 0, 8'h00);
            k++;
        end while (!hw_ready && k < 30);
        step(0, 0, 1, 8'h55);
        step(0, 1, 0, 8'h00);
        check("hs_collision", collision, 1);
        check("hs_grant", hw_grant, 1);

        // Reset in the middle of a frame.
        repeat (15) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check("rst_grant", hw_grant, 0);
        check("rst_tx", tx, 1);
        k = 1;
        while (!hw_ready && k < 30) begin
            step(0, 1, 0, 8'h00);
            k++;
        end
        check("rst_ready_latency", k - 1, 9);

        // Core toggling every 6 cycles never leaves room for HW.
        step(0, 0, 0, 8'h00);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 120; i++) begin
            step(0, ((i / 6) % 2 == 0) ? 1'b0 : 1'b1, 1, 8'($urandom));
            if (hw_ready) cnt++;
            if (hw_grant) cnt2++;
        end
        check("toggle_ready", cnt, 0);
        check("toggle_grant", cnt2, 0);

        // Random traffic against the model.
        cur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur = ~cur;
            step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, cur,
                 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
